timer_cmp_core: RTL and testbench

- Next-generation timer core: free-running CNT_W-bit counter with programmable prescaler, read-snapshot register and N_CH independent compare channels.
- Each channel runs one-shot or periodic and raises a sticky interrupt flag.
- Sits behind the timer CSR block. The CSR block drives loads, strobes and clears; irq_o goes to the system interrupt controller.

---
 rtl/timer_cmp_core_pkg.sv | 13 +
 rtl/timer_cmp_ch.sv | 70 +++++++
 rtl/timer_cmp_core.sv | 125 ++++++++++++
 tb/tb_timer_cmp_core.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_cmp_core_pkg.sv
// Shared definitions for the timer compare core: default widths and channel mode encoding.
package timer_cmp_core_pkg;

    localparam int DEF_CNT_W   = 64;
    localparam int DEF_PRESC_W = 16;
    localparam int DEF_N_CH    = 4;

    typedef enum logic {
        TIMER_CMP_ONESHOT  = 1'b0,
        TIMER_CMP_PERIODIC = 1'b1
    } cmp_mode_e;

endpackage

// File: rtl/timer_cmp_ch.sv
// One compare channel: holds target, period, armed bit, mode and sticky match flag.
module timer_cmp_ch
    import timer_cmp_core_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] cnt_inc_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             load_i,
    input  logic             mode_i,
    input  logic             clr_i,
    output logic             irq_o
);

    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] period_q;
    logic             armed_q;
    cmp_mode_e        mode_q;
    logic             irq_q;
    logic             match;

    // Fires on the edge where the counter steps onto the target.
    assign match = armed_q & tick_i & (cnt_inc_i == target_q);
    assign irq_o = irq_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            target_q <= '0;
            period_q <= '0;
            armed_q  <= 1'b0;
            mode_q   <= TIMER_CMP_ONESHOT;
            irq_q    <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                target_q <= '0;
                period_q <= '0;
                armed_q  <= 1'b0;
                mode_q   <= TIMER_CMP_ONESHOT;
                irq_q    <= 1'b0;
            end else begin
                if (load_i) begin
                    target_q <= cnt_i + val_i;
                    period_q <= val_i;
                    mode_q   <= cmp_mode_e'(mode_i);
                    armed_q  <= (val_i != '0);
                end else if (match) begin
                    if (mode_q == TIMER_CMP_PERIODIC) begin
                        target_q <= target_q + period_q;
                    end else begin
                        armed_q <= 1'b0;
                    end
                end
                // A load suppresses the match; a match beats a simultaneous clear.
                if (match && !load_i) begin
                    irq_q <= 1'b1;
                end else if (clr_i) begin
                    irq_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/timer_cmp_core.sv
// Free-running prescaled counter with snapshot register and N_CH compare channels.
// Optional counter capture input is enabled by defining TIMER_CMP_CAPTURE_EN.
module timer_cmp_core
    import timer_cmp_core_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W,
    parameter int N_CH    = DEF_N_CH
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  en_i,
    input  logic                  rst_i,
    input  logic [PRESC_W-1:0]    presc_i,
    input  logic                  rstrb_i,
    output logic [CNT_W-1:0]      time_o,
    input  logic [N_CH*CNT_W-1:0] cmp_val_i,
    input  logic [N_CH-1:0]       cmp_load_i,
    input  logic [N_CH-1:0]       cmp_mode_i,
    input  logic [N_CH-1:0]       irq_clr_i,
    output logic [N_CH-1:0]       irq_o,
`ifdef TIMER_CMP_CAPTURE_EN
    input  logic                  cap_i,
    output logic [CNT_W-1:0]      cap_o,
    output logic                  cap_vld_o,
    input  logic                  cap_clr_i,
`endif
    output logic                  irq_any_o
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] pcnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   time_q;
    logic               tick;

    // Equality compare only, so lowering presc_i below pcnt lets pcnt run on to its natural wrap.
    assign tick    = en_i & (pcnt_q == presc_i);
    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            time_q <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                pcnt_q <= '0;
                cnt_q  <= '0;
                time_q <= '0;
            end else begin
                if (en_i) begin
                    pcnt_q <= tick ? '0 : pcnt_q + PRESC_ONE;
                end
                if (tick) begin
                    cnt_q <= cnt_inc;
                end
                if (rstrb_i) begin
                    time_q <= cnt_q;
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        timer_cmp_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i     (clk_i),
            .arst_n_i  (arst_n_i),
            .cke_i     (cke_i),
            .rst_i     (rst_i),
            .tick_i    (tick),
            .cnt_i     (cnt_q),
            .cnt_inc_i (cnt_inc),
            .val_i     (cmp_val_i[k*CNT_W +: CNT_W]),
            .load_i    (cmp_load_i[k]),
            .mode_i    (cmp_mode_i[k]),
            .clr_i     (irq_clr_i[k]),
            .irq_o     (irq_o[k])
        );
    end

    assign time_o    = time_q;
    assign irq_any_o = |irq_o;

`ifdef TIMER_CMP_CAPTURE_EN
    logic             cap_prev_q;
    logic [CNT_W-1:0] cap_q;
    logic             cap_vld_q;
    logic             cap_rise;

    assign cap_rise = cap_i & ~cap_prev_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cap_prev_q <= 1'b0;
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                cap_prev_q <= 1'b0;
                cap_q      <= '0;
                cap_vld_q  <= 1'b0;
            end else begin
                cap_prev_q <= cap_i;
                if (cap_rise) begin
                    cap_q     <= cnt_q;
                    cap_vld_q <= 1'b1;
                end else if (cap_clr_i) begin
                    cap_vld_q <= 1'b0;
                end
            end
        end
    end

    assign cap_o     = cap_q;
    assign cap_vld_o = cap_vld_q;
`endif

endmodule

// File: tb/tb_timer_cmp_core.sv
// Self-checking bench for timer_cmp_core (8-bit counter build) with a cycle-level reference model.
module tb_timer_cmp_core;

    localparam int CW = 8;
    localparam int PW = 4;
    localparam int NC = 4;

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic             cke_i;
    logic             en_i;
    logic             rst_i;
    logic [PW-1:0]    presc_i;
    logic             rstrb_i;
    logic [CW-1:0]    time_o;
    logic [NC*CW-1:0] cmp_val_i;
    logic [NC-1:0]    cmp_load_i;
    logic [NC-1:0]    cmp_mode_i;
    logic [NC-1:0]    irq_clr_i;
    logic [NC-1:0]    irq_o;
    logic             irq_any_o;
`ifdef TIMER_CMP_CAPTURE_EN
    logic             cap_i;
    logic [CW-1:0]    cap_o;
    logic             cap_vld_o;
    logic             cap_clr_i;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    timer_cmp_core #(
        .CNT_W   (CW),
        .PRESC_W (PW),
        .N_CH    (NC)
    ) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .en_i       (en_i),
        .rst_i      (rst_i),
        .presc_i    (presc_i),
        .rstrb_i    (rstrb_i),
        .time_o     (time_o),
        .cmp_val_i  (cmp_val_i),
        .cmp_load_i (cmp_load_i),
        .cmp_mode_i (cmp_mode_i),
        .irq_clr_i  (irq_clr_i),
        .irq_o      (irq_o),
`ifdef TIMER_CMP_CAPTURE_EN
        .cap_i      (cap_i),
        .cap_o      (cap_o),
        .cap_vld_o  (cap_vld_o),
        .cap_clr_i  (cap_clr_i),
`endif
        .irq_any_o  (irq_any_o)
    );

    // Reference model: counter value, snapshot, and per-channel absolute deadlines.
    logic [CW-1:0] m_cnt;
    logic [PW-1:0] m_pcnt;
    logic [CW-1:0] m_time;
    logic [CW-1:0] m_tgt [NC];
    logic [CW-1:0] m_per [NC];
    logic          m_armed [NC];
    logic          m_periodic [NC];
    logic [NC-1:0] m_irq;
    logic [CW-1:0] m_cap;
    logic          m_cap_vld;
    logic          m_cap_prev;

    task automatic model_reset();
        m_cnt = '0; m_pcnt = '0; m_time = '0; m_irq = '0;
        m_cap = '0; m_cap_vld = 1'b0; m_cap_prev = 1'b0;
        for (int k = 0; k < NC; k++) begin
            m_tgt[k] = '0; m_per[k] = '0; m_armed[k] = 1'b0; m_periodic[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic          tick;
        logic [CW-1:0] now;
        logic [CW-1:0] nxt;
        logic [CW-1:0] val;
        logic          hit;
        logic          c_in;
        logic          c_clr;
        if (!arst_n_i || !cke_i) return;
        if (rst_i) begin
            model_reset();
            return;
        end
`ifdef TIMER_CMP_CAPTURE_EN
        c_in = cap_i; c_clr = cap_clr_i;
`else
        c_in = 1'b0; c_clr = 1'b0;
`endif
        now  = m_cnt;
        nxt  = now + CW'(1);
        tick = en_i && (m_pcnt == presc_i);
        for (int k = 0; k < NC; k++) begin
            val = cmp_val_i[k*CW +: CW];
            hit = m_armed[k] && tick && (nxt == m_tgt[k]);
            if (cmp_load_i[k]) begin
                m_tgt[k]      = now + val;
                m_per[k]      = val;
                m_periodic[k] = cmp_mode_i[k];
                m_armed[k]    = (val != 0);
            end else if (hit) begin
                if (m_periodic[k]) m_tgt[k] = m_tgt[k] + m_per[k];
                else               m_armed[k] = 1'b0;
            end
            if (hit && !cmp_load_i[k]) m_irq[k] = 1'b1;
            else if (irq_clr_i[k])     m_irq[k] = 1'b0;
        end
        if (rstrb_i) m_time = now;
        if (c_in && !m_cap_prev) begin
            m_cap = now; m_cap_vld = 1'b1;
        end else if (c_clr) begin
            m_cap_vld = 1'b0;
        end
        m_cap_prev = c_in;
        if (en_i) m_pcnt = tick ? '0 : m_pcnt + PW'(1);
        if (tick) m_cnt = nxt;
    endtask

    task automatic drive_idle();
        cke_i = 1'b1; en_i = 1'b1; rst_i = 1'b0; rstrb_i = 1'b0;
        cmp_val_i = '0; cmp_load_i = '0; cmp_mode_i = '0; irq_clr_i = '0;
`ifdef TIMER_CMP_CAPTURE_EN
        cap_i = 1'b0; cap_clr_i = 1'b0;
`endif
    endtask

    // One clock: the model consumes the inputs at the rising edge, outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic sync_clear(input logic [PW-1:0] presc);
        drive_idle();
        presc_i = presc;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic run_to(input logic [CW-1:0] v, input string name);
        int n = 0;
        while (m_cnt != v && n < 600) begin
            cyc();
            n++;
        end
        if (m_cnt != v) begin
            n_tests++; n_fail++;
            $display("FAIL %s: counter did not reach %0d within cycle budget", name, v);
        end
    endtask

    task automatic load_ch(input int k, input logic [CW-1:0] val, input logic periodic);
        cmp_val_i[k*CW +: CW] = val;
        cmp_mode_i[k] = periodic;
        cmp_load_i[k] = 1'b1;
        cyc();
        cmp_load_i[k] = 1'b0;
    endtask

    task automatic strobe();
        rstrb_i = 1'b1;
        cyc();
        rstrb_i = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (time_o !== '0 || irq_o !== '0 || irq_any_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: time_o=%0d irq_o=%b any=%b, required all 0", time_o, irq_o, irq_any_o);
        end
        arst_n_i = 1'b1;
        model_reset();
        repeat (3) cyc();
        n_tests++;
        if (time_o !== '0 || irq_o !== '0 || irq_any_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: time_o=%0d irq_o=%b any=%b, required all 0", time_o, irq_o, irq_any_o);
        end
    endtask

    task automatic test_prescaler();
        sync_clear(PW'(3));
        repeat (40) cyc();
        strobe();
        n_tests++;
        if (time_o !== 8'd10 || time_o !== m_time) begin
            n_fail++;
            $display("FAIL presc3: time_o=%0d required 10 (model %0d)", time_o, m_time);
        end
        sync_clear(PW'(0));
        repeat (40) cyc();
        strobe();
        n_tests++;
        if (time_o !== 8'd40) begin
            n_fail++;
            $display("FAIL presc0: time_o=%0d required 40", time_o);
        end
        // Lower the reload below the running prescaler count: it must wrap, not tick early.
        sync_clear(PW'(7));
        repeat (5) cyc();
        presc_i = PW'(2);
        repeat (13) cyc();
        strobe();
        n_tests++;
        if (time_o !== 8'd0) begin
            n_fail++;
            $display("FAIL presc_wrap_early: time_o=%0d required 0", time_o);
        end
        strobe();
        n_tests++;
        if (time_o !== 8'd1 || time_o !== m_time) begin
            n_fail++;
            $display("FAIL presc_wrap_tick: time_o=%0d required 1 (model %0d)", time_o, m_time);
        end
    endtask

    task automatic test_oneshot();
        logic exp;
        sync_clear(PW'(0));
        run_to(8'd100, "oneshot_pre");
        load_ch(0, 8'd5, 1'b0);
        while (m_cnt != 8'd106) begin
            cyc();
            exp = (m_cnt >= 8'd105);
            n_tests++;
            if (irq_o[0] !== exp || irq_any_o !== exp) begin
                n_fail++;
                $display("FAIL oneshot_fire cnt=%0d: irq_o[0]=%b any=%b required %b", m_cnt, irq_o[0], irq_any_o, exp);
            end
        end
        irq_clr_i[0] = 1'b1;
        cyc();
        irq_clr_i[0] = 1'b0;
        n_tests++;
        if (irq_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_clear: irq_o[0]=%b required 0", irq_o[0]);
        end
        repeat (8) begin
            cyc();
            n_tests++;
            if (irq_o !== '0) begin
                n_fail++;
                $display("FAIL oneshot_refire cnt=%0d: irq_o=%b required 0000", m_cnt, irq_o);
            end
        end
    endtask

    task automatic test_periodic();
        sync_clear(PW'(0));
        load_ch(1, 8'd8, 1'b1);
        run_to(8'd7, "per_7");
        n_tests++;
        if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL per_before8: irq_o[1]=%b required 0", irq_o[1]); end
        cyc();
        n_tests++;
        if (irq_o !== 4'b0010) begin n_fail++; $display("FAIL per_at8: irq_o=%b required 0010", irq_o); end
        irq_clr_i[1] = 1'b1; cyc(); irq_clr_i[1] = 1'b0;
        n_tests++;
        if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL per_clr9: irq_o[1]=%b required 0", irq_o[1]); end
        run_to(8'd15, "per_15");
        irq_clr_i[1] = 1'b1; cyc(); irq_clr_i[1] = 1'b0;
        n_tests++;
        if (irq_o[1] !== 1'b1) begin n_fail++; $display("FAIL per_set_beats_clr16: irq_o[1]=%b required 1", irq_o[1]); end
        irq_clr_i[1] = 1'b1; cyc(); irq_clr_i[1] = 1'b0;
        run_to(8'd23, "per_23");
        n_tests++;
        if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL per_before24: irq_o[1]=%b required 0", irq_o[1]); end
        cyc();
        n_tests++;
        if (irq_o[1] !== 1'b1 || irq_any_o !== 1'b1) begin
            n_fail++; $display("FAIL per_at24: irq_o[1]=%b any=%b required 1", irq_o[1], irq_any_o);
        end
    endtask

    task automatic test_wrap();
        sync_clear(PW'(0));
        run_to(8'd250, "wrap_250");
        load_ch(2, 8'd10, 1'b0);
        run_to(8'd3, "wrap_3");
        n_tests++;
        if (irq_o[2] !== 1'b0) begin n_fail++; $display("FAIL wrap_before4: irq_o[2]=%b required 0", irq_o[2]); end
        cyc();
        n_tests++;
        if (irq_o[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_at4: irq_o[2]=%b required 1", irq_o[2]); end
        load_ch(3, 8'd7, 1'b1);
        load_ch(3, 8'd0, 1'b1);
        repeat (300) cyc();
        n_tests++;
        if (irq_o[3] !== 1'b0) begin n_fail++; $display("FAIL zero_disarm: irq_o[3]=%b required 0", irq_o[3]); end
    endtask

    task automatic test_reset_midop();
        logic [NC-1:0] frz_irq;
        logic [CW-1:0] frz_time;
        sync_clear(PW'(0));
        load_ch(0, 8'd3, 1'b1);
        repeat (10) cyc();
        strobe();
        n_tests++;
        if (irq_o[0] !== 1'b1 || time_o !== m_time) begin
            n_fail++; $display("FAIL midop_pre: irq_o[0]=%b time_o=%0d required 1 / %0d", irq_o[0], time_o, m_time);
        end
        arst_n_i = 1'b0;
        #1;
        n_tests++;
        if (time_o !== '0 || irq_o !== '0 || irq_any_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: time_o=%0d irq_o=%b any=%b required all 0", time_o, irq_o, irq_any_o);
        end
        model_reset();
        @(negedge clk_i);
        arst_n_i = 1'b1;
        // Synchronous clear must override simultaneous loads on every channel.
        cmp_val_i = {NC{8'd2}};
        cmp_mode_i = '1;
        cmp_load_i = '1;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        cmp_load_i = '0;
        repeat (20) cyc();
        n_tests++;
        if (irq_o !== '0) begin n_fail++; $display("FAIL rst_over_load: irq_o=%b required 0000", irq_o); end
        load_ch(0, 8'd5, 1'b1);
        repeat (8) cyc();
        strobe();
        frz_irq = m_irq;
        frz_time = m_time;
        n_tests++;
        if (irq_o[0] !== 1'b1 || time_o !== frz_time) begin
            n_fail++; $display("FAIL cke_pre: irq_o[0]=%b time_o=%0d required 1 / %0d", irq_o[0], time_o, frz_time);
        end
        cke_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rstrb_i = 1'($urandom_range(0, 1));
            irq_clr_i = NC'($urandom);
            cmp_load_i = NC'($urandom);
            cmp_val_i = NC*CW'($urandom);
            rst_i = (i == 10);
            cyc();
            n_tests++;
            if (irq_o !== frz_irq || time_o !== frz_time) begin
                n_fail++; $display("FAIL cke_freeze %0d: irq_o=%b time_o=%0d required %b / %0d", i, irq_o, time_o, frz_irq, frz_time);
            end
        end
        drive_idle();
        strobe();
        n_tests++;
        if (time_o !== m_time) begin
            n_fail++; $display("FAIL cke_resume: time_o=%0d required %0d", time_o, m_time);
        end
    endtask

`ifdef TIMER_CMP_CAPTURE_EN
    task automatic test_capture();
        sync_clear(PW'(0));
        run_to(8'd37, "cap_37");
        cap_i = 1'b1; cyc(); cap_i = 1'b0;
        n_tests++;
        if (cap_o !== 8'd37 || cap_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL cap_first: cap_o=%0d vld=%b required 37 / 1", cap_o, cap_vld_o);
        end
        run_to(8'd60, "cap_60");
        cap_i = 1'b1; cyc(); cap_i = 1'b0;
        n_tests++;
        if (cap_o !== 8'd60 || cap_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL cap_second: cap_o=%0d vld=%b required 60 / 1", cap_o, cap_vld_o);
        end
        cap_clr_i = 1'b1; cyc();
        n_tests++;
        if (cap_vld_o !== 1'b0) begin n_fail++; $display("FAIL cap_clr: vld=%b required 0", cap_vld_o); end
        cap_i = 1'b1; cyc(); cap_i = 1'b0; cap_clr_i = 1'b0;
        n_tests++;
        if (cap_vld_o !== 1'b1 || cap_o !== m_cap) begin
            n_fail++; $display("FAIL cap_edge_beats_clr: cap_o=%0d vld=%b required %0d / 1", cap_o, cap_vld_o, m_cap);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cke_i   = ($urandom_range(0, 9) != 0);
            en_i    = ($urandom_range(0, 4) != 0);
            rst_i   = ($urandom_range(0, 299) == 0);
            rstrb_i = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0) presc_i = PW'($urandom_range(0, 3));
            for (int k = 0; k < NC; k++) begin
                cmp_load_i[k] = ($urandom_range(0, 19) == 0);
                cmp_val_i[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
                cmp_mode_i[k] = 1'($urandom_range(0, 1));
                irq_clr_i[k]  = ($urandom_range(0, 7) == 0);
            end
`ifdef TIMER_CMP_CAPTURE_EN
            cap_i     = ($urandom_range(0, 3) == 0);
            cap_clr_i = ($urandom_range(0, 7) == 0);
`endif
            cyc();
            n_tests++;
            if (time_o !== m_time || irq_o !== m_irq || irq_any_o !== (|m_irq)) begin
                n_fail++;
                $display("FAIL random %0d: time_o=%0d irq_o=%b any=%b required %0d / %b / %b",
                         i, time_o, irq_o, irq_any_o, m_time, m_irq, |m_irq);
            end
`ifdef TIMER_CMP_CAPTURE_EN
            n_tests++;
            if (cap_o !== m_cap || cap_vld_o !== m_cap_vld) begin
                n_fail++;
                $display("FAIL random_cap %0d: cap_o=%0d vld=%b required %0d / %b", i, cap_o, cap_vld_o, m_cap, m_cap_vld);
            end
`endif
        end
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n_i = 1'b0;
        presc_i  = '0;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk_i);
        test_reset();
        test_prescaler();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_reset_midop();
`ifdef TIMER_CMP_CAPTURE_EN
        test_capture();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
